fifo_cal_reg: RTL and testbench

- Sequential stage directly downstream of fifo_ns in the 8-deep FIFO.
- Registers next_state into the current state, which is fed back to fifo_ns.
- Maintains the head/tail pointers and data_count, and generates the memory write/read strobes with their addresses.
- Generates the registered status/handshake flags (full, empty, wr_ack, wr_err, rd_ack, rd_err) consumed by the FIFO top and register file.

---
 rtl/fifo_cal_reg_if.sv | 46 ++++
 rtl/fifo_cal_reg.sv | 155 +++++++++++++++
 tb/tb_fifo_cal_reg.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_cal_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_cal_reg_if
//  Description : Bundle between fifo_ns/FIFO top (master) and the fifo_cal_reg
//                sequential stage (slave).
//                next_state           : 3-bit action selected by fifo_ns
//                state, data_count    : fed back to fifo_ns
//                head, tail           : read / write pointers
//                we/waddr, re/raddr   : memory strobes and addresses
//                full, empty          : occupancy flags
//                wr_ack/wr_err/rd_ack/rd_err : single-cycle handshake pulses
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_cal_reg_if #(
    parameter int AW = 3,
    parameter int CW = 4
);
    logic [2:0]    next_state;
    logic [2:0]    state;
    logic [CW-1:0] data_count;
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          we;
    logic [AW-1:0] waddr;
    logic          re;
    logic [AW-1:0] raddr;
    logic          full;
    logic          empty;
    logic          wr_ack;
    logic          wr_err;
    logic          rd_ack;
    logic          rd_err;

    modport master (
        output next_state,
        input  state, data_count, head, tail, we, waddr, re, raddr,
        input  full, empty, wr_ack, wr_err, rd_ack, rd_err
    );

    modport slave (
        input  next_state,
        output state, data_count, head, tail, we, waddr, re, raddr,
        output full, empty, wr_ack, wr_err, rd_ack, rd_err
    );
endinterface
`default_nettype wire

// File: rtl/fifo_cal_reg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_cal_reg
//  Description : Sequential stage after fifo_ns in the FIFO. Registers the
//                selected action as the current state and performs it:
//                pointer/count update, memory strobes with addresses and
//                registered status/handshake flags. All outputs are one
//                clock after next_state.
//  Ports       : clk  - system clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - fifo_cal_reg_if.slave (next_state in, all else out)
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_cal_reg #(
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CW    = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    fifo_cal_reg_if.slave     bus
);

    typedef enum logic [2:0] {
        ST_INIT     = 3'b000,
        ST_WRITE    = 3'b001,
        ST_WR_ERROR = 3'b010,
        ST_NO_OP    = 3'b011,
        ST_READ     = 3'b101,
        ST_RD_ERROR = 3'b110
    } state_t;

    localparam logic [CW-1:0] c_FULL = CW'(DEPTH);
    localparam logic [AW-1:0] c_LAST = AW'(DEPTH - 1);

    logic [2:0]    r_state;
    logic [CW-1:0] r_count, w_count;
    logic [AW-1:0] r_head,  w_head;
    logic [AW-1:0] r_tail,  w_tail;
    logic          r_we,    w_we;
    logic [AW-1:0] r_waddr, w_waddr;
    logic          r_re,    w_re;
    logic [AW-1:0] r_raddr, w_raddr;
    logic          r_full,  r_empty;
    logic          r_wr_ack, w_wr_ack;
    logic          r_wr_err, w_wr_err;
    logic          r_rd_ack, w_rd_ack;
    logic          r_rd_err, w_rd_err;

    // Pointer increment modulo DEPTH (also correct for non-power-of-two).
    function automatic logic [AW-1:0] f_inc(input logic [AW-1:0] p);
        return (p == c_LAST) ? '0 : p + AW'(1);
    endfunction

    // Action decode is driven by next_state; the registered state is only
    // a copy for fifo_ns. Illegal encodings fall into the default (no-op).
    always_comb begin
        w_count  = r_count;
        w_head   = r_head;
        w_tail   = r_tail;
        w_we     = 1'b0;
        w_waddr  = r_waddr;
        w_re     = 1'b0;
        w_raddr  = r_raddr;
        w_wr_ack = 1'b0;
        w_wr_err = 1'b0;
        w_rd_ack = 1'b0;
        w_rd_err = 1'b0;
        case (bus.next_state)
            ST_INIT: begin
                w_count = '0;
                w_head  = '0;
                w_tail  = '0;
            end
            ST_WRITE: begin
                // A write while full is a fifo_ns fault; degrade to overflow.
                if (r_count != c_FULL) begin
                    w_we     = 1'b1;
                    w_waddr  = r_tail;
                    w_tail   = f_inc(r_tail);
                    w_count  = r_count + CW'(1);
                    w_wr_ack = 1'b1;
                end else begin
                    w_wr_err = 1'b1;
                end
            end
            ST_WR_ERROR: w_wr_err = 1'b1;
            ST_READ: begin
                if (r_count != '0) begin
                    w_re     = 1'b1;
                    w_raddr  = r_head;
                    w_head   = f_inc(r_head);
                    w_count  = r_count - CW'(1);
                    w_rd_ack = 1'b1;
                end else begin
                    w_rd_err = 1'b1;
                end
            end
            ST_RD_ERROR: w_rd_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_INIT;
            r_count  <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_re     <= 1'b0;
            r_raddr  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
            r_wr_ack <= 1'b0;
            r_wr_err <= 1'b0;
            r_rd_ack <= 1'b0;
            r_rd_err <= 1'b0;
        end else begin
            r_state  <= bus.next_state;
            r_count  <= w_count;
            r_head   <= w_head;
            r_tail   <= w_tail;
            r_we     <= w_we;
            r_waddr  <= w_waddr;
            r_re     <= w_re;
            r_raddr  <= w_raddr;
            // Flags follow the updated count in the same cycle.
            r_full   <= (w_count == c_FULL);
            r_empty  <= (w_count == '0);
            r_wr_ack <= w_wr_ack;
            r_wr_err <= w_wr_err;
            r_rd_ack <= w_rd_ack;
            r_rd_err <= w_rd_err;
        end
    end

    assign bus.state      = r_state;
    assign bus.data_count = r_count;
    assign bus.head       = r_head;
    assign bus.tail       = r_tail;
    assign bus.we         = r_we;
    assign bus.waddr      = r_waddr;
    assign bus.re         = r_re;
    assign bus.raddr      = r_raddr;
    assign bus.full       = r_full;
    assign bus.empty      = r_empty;
    assign bus.wr_ack     = r_wr_ack;
    assign bus.wr_err     = r_wr_err;
    assign bus.rd_ack     = r_rd_ack;
    assign bus.rd_err     = r_rd_err;

endmodule
`default_nettype wire

// File: tb/tb_fifo_cal_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_cal_reg
//  Description : Self-checking bench for fifo_cal_reg. Directed vector table,
//                hand-written wrap/reset/init sequences and a randomized run,
//                all compared against a queue-based occupancy model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_cal_reg;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_cal_reg_if #(.AW(3), .CW(4)) bus ();

    fifo_cal_reg #(.DEPTH(DEPTH), .AW(3), .CW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: the queue holds the slot index of every stored entry,
    // oldest first. Head is derived from tail and occupancy.
    int q[$];
    int m_tail, m_state, m_wa, m_ra;
    logic m_we, m_re, m_wack, m_werr, m_rack, m_rerr;

    function automatic int m_head();
        return (m_tail - q.size() + DEPTH) % DEPTH;
    endfunction

    task automatic model_update(input logic r, input logic [2:0] ns);
        m_we = 0; m_re = 0; m_wack = 0; m_werr = 0; m_rack = 0; m_rerr = 0;
        if (r) begin
            q.delete(); m_tail = 0; m_state = 0; m_wa = 0; m_ra = 0;
        end else begin
            m_state = int'(ns);
            case (ns)
                3'd0: begin q.delete(); m_tail = 0; end
                3'd1: if (q.size() < DEPTH) begin
                          q.push_back(m_tail); m_wa = m_tail; m_we = 1; m_wack = 1;
                          m_tail = (m_tail + 1) % DEPTH;
                      end else m_werr = 1;
                3'd2: m_werr = 1;
                3'd5: if (q.size() > 0) begin
                          m_ra = q.pop_front(); m_re = 1; m_rack = 1;
                      end else m_rerr = 1;
                3'd6: m_rerr = 1;
                default: ;
            endcase
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic check_model();
        chk("state",  32'(bus.state),      32'(m_state));
        chk("count",  32'(bus.data_count), 32'(q.size()));
        chk("head",   32'(bus.head),       32'(m_head()));
        chk("tail",   32'(bus.tail),       32'(m_tail));
        chk("we",     32'(bus.we),         32'(m_we));
        chk("re",     32'(bus.re),         32'(m_re));
        if (m_we) chk("waddr", 32'(bus.waddr), 32'(m_wa));
        if (m_re) chk("raddr", 32'(bus.raddr), 32'(m_ra));
        chk("full",   32'(bus.full),       32'(q.size() == DEPTH));
        chk("empty",  32'(bus.empty),      32'(q.size() == 0));
        chk("wr_ack", 32'(bus.wr_ack),     32'(m_wack));
        chk("wr_err", 32'(bus.wr_err),     32'(m_werr));
        chk("rd_ack", 32'(bus.rd_ack),     32'(m_rack));
        chk("rd_err", 32'(bus.rd_err),     32'(m_rerr));
    endtask

    // Apply inputs, take one edge, then sample 1ns after it.
    task automatic step(input logic r, input logic [2:0] ns);
        rst = r;
        bus.next_state = ns;
        @(posedge clk);
        cyc++;
        model_update(r, ns);
        #1;
        check_model();
    endtask

    typedef struct {
        logic       r;
        logic [2:0] ns;
        int         cnt, head, tail;
        logic       we;
        int         wa;
        logic       re;
        int         ra;
        logic [5:0] fl;   // {full, empty, wr_ack, wr_err, rd_ack, rd_err}
    } vec_t;

    vec_t tbl[26];

    function automatic vec_t mk(input logic r, input logic [2:0] ns, input int cnt,
                                input int hd, input int tl, input logic we, input int wa,
                                input logic re, input int ra, input logic [5:0] fl);
        vec_t v;
        v.r = r; v.ns = ns; v.cnt = cnt; v.head = hd; v.tail = tl;
        v.we = we; v.wa = wa; v.re = re; v.ra = ra; v.fl = fl;
        return v;
    endfunction

    initial begin
        logic [2:0] picks[16];
        int exp_ra[6];
        int n;

        bus.next_state = 3'd0;
        exp_ra = '{5, 6, 7, 0, 1, 2};
        picks  = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd5, 3'd5,
                   3'd5, 3'd5, 3'd5, 3'd5, 3'd2, 3'd6, 3'd3, 3'd4};

        // Directed table: reset, idle, fill, overflow, drain, underflow, illegal.
        n = 0;
        tbl[n++] = mk(1, 3'd1, 0, 0, 0, 0, 0, 0, 0, 6'b010000);
        for (int i = 0; i < 3; i++) tbl[n++] = mk(0, 3'd3, 0, 0, 0, 0, 0, 0, 0, 6'b010000);
        for (int i = 0; i < 8; i++)
            tbl[n++] = mk(0, 3'd1, i + 1, 0, (i + 1) % 8, 1, i, 0, 0,
                          (i == 7) ? 6'b101000 : 6'b001000);
        tbl[n++] = mk(0, 3'd1, 8, 0, 0, 0, 7, 0, 0, 6'b100100);
        tbl[n++] = mk(0, 3'd2, 8, 0, 0, 0, 7, 0, 0, 6'b100100);
        for (int i = 0; i < 8; i++)
            tbl[n++] = mk(0, 3'd5, 7 - i, (i + 1) % 8, 0, 0, 7, 1, i,
                          (i == 7) ? 6'b010010 : 6'b000010);
        tbl[n++] = mk(0, 3'd5, 0, 0, 0, 0, 7, 0, 7, 6'b010001);
        tbl[n++] = mk(0, 3'd6, 0, 0, 0, 0, 7, 0, 7, 6'b010001);
        tbl[n++] = mk(0, 3'd4, 0, 0, 0, 0, 7, 0, 7, 6'b010000);
        tbl[n++] = mk(0, 3'd7, 0, 0, 0, 0, 7, 0, 7, 6'b010000);

        for (int i = 0; i < 26; i++) begin
            step(tbl[i].r, tbl[i].ns);
            chk("t_state", 32'(bus.state), tbl[i].r ? 32'd0 : 32'(tbl[i].ns));
            chk("t_count", 32'(bus.data_count), 32'(tbl[i].cnt));
            chk("t_head",  32'(bus.head),  32'(tbl[i].head));
            chk("t_tail",  32'(bus.tail),  32'(tbl[i].tail));
            chk("t_we",    32'(bus.we),    32'(tbl[i].we));
            chk("t_waddr", 32'(bus.waddr), 32'(tbl[i].wa));
            chk("t_re",    32'(bus.re),    32'(tbl[i].re));
            chk("t_raddr", 32'(bus.raddr), 32'(tbl[i].ra));
            chk("t_flags", 32'({bus.full, bus.empty, bus.wr_ack, bus.wr_err,
                                bus.rd_ack, bus.rd_err}), 32'(tbl[i].fl));
        end

        // Wrap-around: 5 writes, 5 reads, 6 writes, then 6 reads.
        step(1, 3'd0);
        for (int i = 0; i < 5; i++) step(0, 3'd1);
        for (int i = 0; i < 5; i++) step(0, 3'd5);
        for (int i = 0; i < 6; i++) step(0, 3'd1);
        chk("wrap_tail",  32'(bus.tail), 32'd3);
        chk("wrap_head",  32'(bus.head), 32'd5);
        chk("wrap_count", 32'(bus.data_count), 32'd6);
        for (int i = 0; i < 6; i++) begin
            step(0, 3'd5);
            chk("wrap_raddr", 32'(bus.raddr), 32'(exp_ra[i]));
        end

        // Reset in the middle of a write burst at count 4.
        step(1, 3'd0);
        for (int i = 0; i < 4; i++) step(0, 3'd1);
        chk("burst_count", 32'(bus.data_count), 32'd4);
        step(1, 3'd1);
        chk("rst_state", 32'(bus.state), 32'd0);
        chk("rst_count", 32'(bus.data_count), 32'd0);
        chk("rst_ptrs",  32'({bus.head, bus.tail}), 32'd0);
        chk("rst_strb",  32'({bus.we, bus.re, bus.waddr, bus.raddr}), 32'd0);
        chk("rst_flags", 32'({bus.full, bus.empty, bus.wr_ack, bus.wr_err,
                              bus.rd_ack, bus.rd_err}), 32'b010000);

        // INIT clears pointers and count mid-operation.
        for (int i = 0; i < 3; i++) step(0, 3'd1);
        step(0, 3'd0);
        chk("init_count", 32'(bus.data_count), 32'd0);
        chk("init_tail",  32'(bus.tail), 32'd0);
        chk("init_we",    32'(bus.we), 32'd0);

        // Randomized run against the model.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 199) == 0), picks[$urandom_range(0, 15)]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Absolute time bound so the run can never hang.
    initial begin
        #500000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
